// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller in the ID stage.
// Detects load-use and branch-on-load hazards that forwarding cannot hide,
// freezes PC and IF/ID while bubbling ID/EX, flushes IF/ID on a resolved
// taken branch, and sequences a CGRA offload (start/done with timeout)
// while holding the core.
module hazard_stall_ctrl #(
    parameter int CGRA_TIMEOUT = 1024
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] ID_RS_i,
    input  logic [4:0] ID_RT_i,
    input  logic       ID_UsesRT_i,
    input  logic       ID_Branch_i,
    input  logic       ID_CgraReq_i,
    input  logic       Branch_taken_i,
    input  logic       ID_EX_MemRead_i,
    input  logic [4:0] ID_EX_RD_i,
    input  logic       EX_MEM_MemRead_i,
    input  logic [4:0] EX_MEM_RD_i,
    input  logic       cgra_done_i,
    output logic       pc_write_o,
    output logic       if_id_write_o,
    output logic       id_ex_bubble_o,
    output logic       if_id_flush_o,
    output logic       cgra_start_o,
    output logic       cgra_busy_o,
    output logic       cgra_timeout_o
);

    localparam int CW = $clog2(CGRA_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(CGRA_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      br_cnt_q, br_cnt_d;
    logic [CW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic            timeout_q, timeout_d;

    logic ex_match, mem_match;
    logic ex_load_hit, mem_load_hit;
    logic load_use, br_load, cgra_stall, stall;

    // A producer register matches when it is non-zero and feeds rs, or rt if rt is read.
    assign ex_match  = (ID_EX_RD_i != 5'd0) &&
                       ((ID_EX_RD_i == ID_RS_i) || (ID_UsesRT_i && (ID_EX_RD_i == ID_RT_i)));
    assign mem_match = (EX_MEM_RD_i != 5'd0) &&
                       ((EX_MEM_RD_i == ID_RS_i) || (ID_UsesRT_i && (EX_MEM_RD_i == ID_RT_i)));

    // Only loads cause stalls; ALU results in EX/MEM reach ID through forwarding.
    assign ex_load_hit  = ID_EX_MemRead_i && ex_match;
    assign mem_load_hit = EX_MEM_MemRead_i && mem_match;

    assign load_use   = ex_load_hit;
    // br_cnt keeps the branch stalled for the cycle after the EX-load match,
    // when the load data is still one stage away from the ID comparator.
    assign br_load    = ID_Branch_i && (ex_load_hit || mem_load_hit || (br_cnt_q != 2'd0));
    assign cgra_stall = (state_q == S_START) || (state_q == S_WAIT);
    assign stall      = load_use || br_load || cgra_stall;

    // Outputs are forced to their pass-through values while reset is held.
    assign pc_write_o     = rst_i || !stall;
    assign if_id_write_o  = rst_i || !stall;
    assign id_ex_bubble_o = !rst_i && stall;
    assign if_id_flush_o  = !rst_i && Branch_taken_i && !stall;
    assign cgra_start_o   = !rst_i && (state_q == S_START);
    assign cgra_busy_o    = !rst_i && (state_q != S_IDLE);
    assign cgra_timeout_o = timeout_q;

    // Next-state for the branch-on-load counter and the CGRA offload sequencer.
    always_comb begin
        br_cnt_d  = br_cnt_q;
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        timeout_d = timeout_q;

        if (!ID_Branch_i) begin
            br_cnt_d = 2'd0;
        end else if (ex_load_hit) begin
            br_cnt_d = 2'd1;
        end else if (br_cnt_q != 2'd0) begin
            br_cnt_d = br_cnt_q - 2'd1;
        end

        case (state_q)
            S_IDLE: begin
                // Operands must be forwardable before the offload is launched.
                if (ID_CgraReq_i && !load_use && !br_load) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                tmo_cnt_d = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // done takes priority over a coincident terminal count
                if (cgra_done_i) begin
                    state_d = S_DRAIN;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_DRAIN;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            br_cnt_q  <= 2'd0;
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            br_cnt_q  <= br_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed vectors, a behavioural reference
// model compared against the DUT every cycle, and literal spot checks.
module tb_hazard_stall_ctrl;

    localparam int TMO = 8;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [4:0] ID_RS_i, ID_RT_i, ID_EX_RD_i, EX_MEM_RD_i;
    logic       ID_UsesRT_i, ID_Branch_i, ID_CgraReq_i, Branch_taken_i;
    logic       ID_EX_MemRead_i, EX_MEM_MemRead_i, cgra_done_i;
    logic       pc_write_o, if_id_write_o, id_ex_bubble_o, if_id_flush_o;
    logic       cgra_start_o, cgra_busy_o, cgra_timeout_o;

    int n_checks = 0;
    int n_err    = 0;

    hazard_stall_ctrl #(.CGRA_TIMEOUT(TMO)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .ID_RS_i         (ID_RS_i),
        .ID_RT_i         (ID_RT_i),
        .ID_UsesRT_i     (ID_UsesRT_i),
        .ID_Branch_i     (ID_Branch_i),
        .ID_CgraReq_i    (ID_CgraReq_i),
        .Branch_taken_i  (Branch_taken_i),
        .ID_EX_MemRead_i (ID_EX_MemRead_i),
        .ID_EX_RD_i      (ID_EX_RD_i),
        .EX_MEM_MemRead_i(EX_MEM_MemRead_i),
        .EX_MEM_RD_i     (EX_MEM_RD_i),
        .cgra_done_i     (cgra_done_i),
        .pc_write_o      (pc_write_o),
        .if_id_write_o   (if_id_write_o),
        .id_ex_bubble_o  (id_ex_bubble_o),
        .if_id_flush_o   (if_id_flush_o),
        .cgra_start_o    (cgra_start_o),
        .cgra_busy_o     (cgra_busy_o),
        .cgra_timeout_o  (cgra_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Offload phase: 0 idle, 1 start, 2 waiting, 3 drain.
    int   m_phase   = 0;
    int   m_waited  = 0;   // WAIT cycles already completed
    logic m_timeout = 1'b0;
    logic m_prev_br_ex = 1'b0; // previous cycle: branch in ID with a matching load in EX

    function automatic logic reads(input logic [4:0] rd, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic use_rt);
        return (rd != 5'd0) && ((rd == rs) || (use_rt && (rd == rt)));
    endfunction

    logic m_lu, m_bl, m_stall;
    assign m_lu = ID_EX_MemRead_i && reads(ID_EX_RD_i, ID_RS_i, ID_RT_i, ID_UsesRT_i);
    // Branch needs the loaded value in ID: stall while the load is in EX or MEM,
    // including the cycle after an EX match when the load has moved on to MEM.
    assign m_bl = ID_Branch_i && (m_lu ||
                  (EX_MEM_MemRead_i && reads(EX_MEM_RD_i, ID_RS_i, ID_RT_i, ID_UsesRT_i)) ||
                  m_prev_br_ex);
    assign m_stall = m_lu || m_bl || (m_phase == 1) || (m_phase == 2);

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_phase      <= 0;
            m_waited     <= 0;
            m_timeout    <= 1'b0;
            m_prev_br_ex <= 1'b0;
        end else begin
            m_prev_br_ex <= ID_Branch_i && m_lu;
            case (m_phase)
                0: if (ID_CgraReq_i && !m_lu && !m_bl) m_phase <= 1;
                1: begin m_phase <= 2; m_waited <= 0; end
                2: begin
                    if (cgra_done_i) m_phase <= 3;
                    else if (m_waited + 1 == TMO) begin
                        m_timeout <= 1'b1;
                        m_phase   <= 3;
                    end else m_waited <= m_waited + 1;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    // Every cycle: compare all outputs against the model, away from the active edge.
    always @(negedge clk_i) begin
        if (rst_i) begin
            check("rst_pc_write",  pc_write_o,     1'b1);
            check("rst_if_id_wr",  if_id_write_o,  1'b1);
            check("rst_bubble",    id_ex_bubble_o, 1'b0);
            check("rst_flush",     if_id_flush_o,  1'b0);
            check("rst_start",     cgra_start_o,   1'b0);
            check("rst_busy",      cgra_busy_o,    1'b0);
            check("rst_timeout",   cgra_timeout_o, 1'b0);
        end else begin
            check("pc_write",  pc_write_o,     !m_stall);
            check("if_id_wr",  if_id_write_o,  !m_stall);
            check("bubble",    id_ex_bubble_o, m_stall);
            check("flush",     if_id_flush_o,  Branch_taken_i && !m_stall);
            check("start",     cgra_start_o,   m_phase == 1);
            check("busy",      cgra_busy_o,    m_phase != 0);
            check("timeout",   cgra_timeout_o, m_timeout);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs;
        ID_RS_i = 5'd0; ID_RT_i = 5'd0; ID_UsesRT_i = 1'b0; ID_Branch_i = 1'b0;
        ID_CgraReq_i = 1'b0; Branch_taken_i = 1'b0;
        ID_EX_MemRead_i = 1'b0; ID_EX_RD_i = 5'd0;
        EX_MEM_MemRead_i = 1'b0; EX_MEM_RD_i = 5'd0; cgra_done_i = 1'b0;
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        idle_inputs();
        #2;
        check("lit_reset_pc", pc_write_o, 1'b1);
        check("lit_reset_busy", cgra_busy_o, 1'b0);
        repeat (2) step();
        rst_i = 1'b0;

        // 1: load-use, one stall cycle then release
        ID_EX_MemRead_i = 1'b1; ID_EX_RD_i = 5'd5; ID_RS_i = 5'd5;
        #1;
        check("s1_pc_hold", pc_write_o, 1'b0);
        check("s1_ifid_hold", if_id_write_o, 1'b0);
        check("s1_bubble", id_ex_bubble_o, 1'b1);
        step();
        ID_EX_MemRead_i = 1'b0; ID_EX_RD_i = 5'd0;
        EX_MEM_MemRead_i = 1'b1; EX_MEM_RD_i = 5'd5;
        #1;
        check("s1_release_pc", pc_write_o, 1'b1);
        check("s1_release_bubble", id_ex_bubble_o, 1'b0);
        step(); idle_inputs();

        // 2: branch on load in EX -> 2 stall cycles, then flush on taken
        ID_EX_MemRead_i = 1'b1; ID_EX_RD_i = 5'd3; ID_Branch_i = 1'b1; ID_RS_i = 5'd3;
        #1;
        check("s2_stall1", pc_write_o, 1'b0);
        step();
        ID_EX_MemRead_i = 1'b0; ID_EX_RD_i = 5'd0;
        EX_MEM_MemRead_i = 1'b1; EX_MEM_RD_i = 5'd3; Branch_taken_i = 1'b1;
        #1;
        check("s2_stall2", pc_write_o, 1'b0);
        check("s2_flush_suppressed", if_id_flush_o, 1'b0);
        step();
        EX_MEM_MemRead_i = 1'b0; EX_MEM_RD_i = 5'd0;
        #1;
        check("s2_flush", if_id_flush_o, 1'b1);
        check("s2_pc_free", pc_write_o, 1'b1);
        step(); idle_inputs();

        // 3: r0 load and ALU producer never stall; rt only when read
        ID_EX_MemRead_i = 1'b1; ID_EX_RD_i = 5'd0; ID_RS_i = 5'd0;
        #1; check("s3_r0_load", pc_write_o, 1'b1);
        step();
        ID_EX_MemRead_i = 1'b0; ID_EX_RD_i = 5'd7; ID_Branch_i = 1'b1; ID_RS_i = 5'd7;
        #1; check("s3_alu_branch", pc_write_o, 1'b1);
        step(); idle_inputs();
        ID_EX_MemRead_i = 1'b1; ID_EX_RD_i = 5'd9; ID_RT_i = 5'd9; ID_RS_i = 5'd1;
        #1; check("s3_rt_unused", pc_write_o, 1'b1);
        step();
        ID_UsesRT_i = 1'b1;
        #1; check("s3_rt_used", pc_write_o, 1'b0);
        step(); idle_inputs();
        EX_MEM_MemRead_i = 1'b1; EX_MEM_RD_i = 5'd4; ID_Branch_i = 1'b1; ID_RS_i = 5'd4;
        #1; check("s3_mem_load_branch", pc_write_o, 1'b0);
        step(); idle_inputs();

        // 4: CGRA offload, held off by load-use first, done 5 cycles after start
        ID_CgraReq_i = 1'b1; ID_EX_MemRead_i = 1'b1; ID_EX_RD_i = 5'd6; ID_RS_i = 5'd6;
        step();
        ID_EX_MemRead_i = 1'b0; ID_EX_RD_i = 5'd0;
        #1; check("s4_blocked_idle", cgra_busy_o, 1'b0);
        step();                                   // START
        cgra_done_i = 1'b1;                       // ignored outside WAIT
        #1;
        check("s4_start", cgra_start_o, 1'b1);
        check("s4_start_stall", pc_write_o, 1'b0);
        step();                                   // WAIT1
        cgra_done_i = 1'b0;
        #1; check("s4_start_once", cgra_start_o, 1'b0);
        repeat (4) step();                        // WAIT5
        cgra_done_i = 1'b1;
        #1; check("s4_wait_stall", pc_write_o, 1'b0);
        step();                                   // DRAIN
        cgra_done_i = 1'b0; ID_CgraReq_i = 1'b0;
        #1;
        check("s4_drain_busy", cgra_busy_o, 1'b1);
        check("s4_drain_free", pc_write_o, 1'b1);
        step();
        #1; check("s4_idle", cgra_busy_o, 1'b0);
        idle_inputs();

        // 5b: done coincides with the terminal count -> no timeout
        ID_CgraReq_i = 1'b1;
        step();                                   // START
        step();                                   // WAIT1
        repeat (7) step();                        // WAIT8
        cgra_done_i = 1'b1;
        step();                                   // DRAIN
        cgra_done_i = 1'b0; ID_CgraReq_i = 1'b0;
        #1;
        check("s5_done_wins", cgra_timeout_o, 1'b0);
        check("s5_done_drain", cgra_busy_o, 1'b1);
        step();

        // 5a: done never arrives -> timeout after TMO WAIT cycles, sticky
        ID_CgraReq_i = 1'b1;
        step();                                   // START
        step();                                   // WAIT1
        repeat (7) step();                        // WAIT8
        #1; check("s5_not_yet", cgra_timeout_o, 1'b0);
        step();                                   // DRAIN
        ID_CgraReq_i = 1'b0;
        #1;
        check("s5_timeout_set", cgra_timeout_o, 1'b1);
        check("s5_timeout_drain", pc_write_o, 1'b1);
        step();
        #1;
        check("s5_timeout_sticky", cgra_timeout_o, 1'b1);
        check("s5_back_idle", cgra_busy_o, 1'b0);

        // 6: asynchronous reset mid-WAIT with a hazard present
        ID_CgraReq_i = 1'b1;
        step(); step(); step();                   // START, WAIT1, WAIT2
        ID_EX_MemRead_i = 1'b1; ID_EX_RD_i = 5'd5; ID_RS_i = 5'd5;
        #1;
        rst_i = 1'b1;
        #1;
        check("s6_pc", pc_write_o, 1'b1);
        check("s6_bubble", id_ex_bubble_o, 1'b0);
        check("s6_busy", cgra_busy_o, 1'b0);
        check("s6_timeout_clr", cgra_timeout_o, 1'b0);
        step();
        rst_i = 1'b0;
        idle_inputs();
        #1;
        check("s6_idle_after", cgra_busy_o, 1'b0);
        step(); step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
